// File: rtl/prime_checker_n_pkg.sv
// Shared types and constants for the trial-division primality tester.
// The FSM state is one-hot; odd divisors start at FIRST_ODD_DIV.
package prime_checker_n_pkg;
   localparam int DEFAULT_WIDTH = 8;
   localparam int FIRST_ODD_DIV = 3;

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_CHECK = 5'b00010,
      S_DIV   = 5'b00100,
      S_EVAL  = 5'b01000,
      S_DONE  = 5'b10000
   } state_t;
endpackage

// File: rtl/prime_checker_n_if.sv
// Operand/result handshake bundle for prime_checker_n.
// The _i/_o suffixes are named from the checker's point of view.
interface prime_checker_n_if
   import prime_checker_n_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH);

   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] data_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic             prime_o;
   logic [WIDTH-1:0] factor_o;
   logic [WIDTH-1:0] trials_o;

   modport master (
      output in_valid_i, data_i, out_ready_i,
      input  in_ready_o, out_valid_o, prime_o, factor_o, trials_o
   );

   modport slave (
      input  in_valid_i, data_i, out_ready_i,
      output in_ready_o, out_valid_o, prime_o, factor_o, trials_o
   );
endinterface

// File: rtl/prime_checker_n_seq_mod.sv
// Sequential restoring remainder unit: one quotient bit per clock.
// The first bit is taken on the start edge, so done pulses exactly WIDTH cycles after start.
module prime_checker_n_seq_mod #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             abort_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH:0]   divisor_i,
   output logic             done_o,
   output logic [WIDTH:0]   rem_o
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH:0]   r_dsr;
   logic [WIDTH:0]   r_rem;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH:0]   w_rem_in;
   logic [WIDTH-1:0] w_dvd_in;
   logic [WIDTH:0]   w_dsr_in;
   logic [WIDTH+1:0] w_trial;
   logic [WIDTH+1:0] w_diff;
   logic [WIDTH:0]   w_rem_next;

   // On start the step uses the fresh operands directly instead of the registers.
   assign w_rem_in   = start_i ? '0 : r_rem;
   assign w_dvd_in   = start_i ? dividend_i : r_dvd;
   assign w_dsr_in   = start_i ? divisor_i : r_dsr;
   assign w_trial    = {w_rem_in, w_dvd_in[WIDTH-1]};
   assign w_diff     = w_trial - {1'b0, w_dsr_in};
   assign w_rem_next = (w_trial >= {1'b0, w_dsr_in}) ? w_diff[WIDTH:0] : w_trial[WIDTH:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dvd  <= '0;
         r_dsr  <= '0;
         r_rem  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (abort_i) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (start_i || r_busy) begin
         r_rem <= w_rem_next;
         r_dvd <= {w_dvd_in[WIDTH-2:0], 1'b0};
         r_dsr <= w_dsr_in;
         if (start_i) begin
            r_cnt  <= CW'(WIDTH - 1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
         end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_busy <= (r_cnt != CW'(1));
            r_done <= (r_cnt == CW'(1));
         end
      end else begin
         r_done <= 1'b0;
      end
   end

   assign done_o = r_done;
   assign rem_o  = r_rem;
endmodule

// File: rtl/prime_checker_n.sv
// Multi-cycle primality tester: trial division by 2, then odd divisors until d*d > n.
// Reports prime flag, smallest nontrivial factor and the number of remainder passes.
module prime_checker_n
   import prime_checker_n_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   prime_checker_n_if.slave bus
);
   localparam int NW = 2 * WIDTH + 2;

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_prime;
   logic [WIDTH-1:0] r_factor;
   logic [WIDTH-1:0] r_trials_out;
   logic [WIDTH-1:0] r_n;
   logic [WIDTH:0]   r_d;
   logic [WIDTH-1:0] r_trials;

   logic [NW-1:0]    w_n_ext;
   logic [WIDTH:0]   w_d_next;
   logic [NW-1:0]    w_d_next_sq;
   logic             w_check_div;
   logic             w_chk_prime;
   logic [WIDTH-1:0] w_chk_factor;
   logic             w_start;
   logic [WIDTH:0]   w_divisor;
   logic             w_done;
   logic [WIDTH:0]   w_rem;

   assign w_n_ext      = NW'(r_n);
   assign w_d_next     = r_d + (WIDTH+1)'(2);
   assign w_d_next_sq  = NW'(w_d_next) * NW'(w_d_next);
   // Odd n >= 9 is the only case that needs real division.
   assign w_check_div  = (w_n_ext >= NW'(9)) && r_n[0];
   assign w_chk_prime  = (w_n_ext == NW'(2)) || ((w_n_ext >= NW'(3)) && r_n[0]);
   assign w_chk_factor = ((w_n_ext >= NW'(4)) && !r_n[0]) ? WIDTH'(2) : '0;

   // Division starts in the same cycle the FSM decides to enter DIV.
   assign w_start   = !clear_i &&
                      (((r_state == S_CHECK) && w_check_div) ||
                       ((r_state == S_EVAL) && (w_rem != '0) && !(w_d_next_sq > w_n_ext)));
   assign w_divisor = (r_state == S_EVAL) ? w_d_next : r_d;

   prime_checker_n_seq_mod #(.WIDTH(WIDTH)) u_seq_mod (
      .clk        (clk),
      .rst_n      (rst_n),
      .abort_i    (clear_i),
      .start_i    (w_start),
      .dividend_i (r_n),
      .divisor_i  (w_divisor),
      .done_o     (w_done),
      .rem_o      (w_rem)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_prime      <= 1'b0;
         r_factor     <= '0;
         r_trials_out <= '0;
         r_n          <= '0;
         r_d          <= (WIDTH+1)'(FIRST_ODD_DIV);
         r_trials     <= '0;
      end else if (clear_i) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid_i) begin
                  r_n        <= bus.data_i;
                  r_trials   <= '0;
                  r_d        <= (WIDTH+1)'(FIRST_ODD_DIV);
                  r_in_ready <= 1'b0;
                  r_state    <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_check_div) begin
                  r_trials <= r_trials + 1'b1;
                  r_state  <= S_DIV;
               end else begin
                  r_prime      <= w_chk_prime;
                  r_factor     <= w_chk_factor;
                  r_trials_out <= r_trials;
                  r_out_valid  <= 1'b1;
                  r_state      <= S_DONE;
               end
            end
            S_DIV: begin
               if (w_done) begin
                  r_state <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (w_rem == '0) begin
                  r_prime      <= 1'b0;
                  r_factor     <= r_d[WIDTH-1:0];
                  r_trials_out <= r_trials;
                  r_out_valid  <= 1'b1;
                  r_state      <= S_DONE;
               end else begin
                  r_d <= w_d_next;
                  if (w_d_next_sq > w_n_ext) begin
                     r_prime      <= 1'b1;
                     r_factor     <= '0;
                     r_trials_out <= r_trials;
                     r_out_valid  <= 1'b1;
                     r_state      <= S_DONE;
                  end else begin
                     r_trials <= r_trials + 1'b1;
                     r_state  <= S_DIV;
                  end
               end
            end
            S_DONE: begin
               if (bus.out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready_o  = r_in_ready;
   assign bus.out_valid_o = r_out_valid;
   assign bus.prime_o     = r_prime;
   assign bus.factor_o    = r_factor;
   assign bus.trials_o    = r_trials_out;
endmodule

// File: tb/tb_prime_checker_n.sv
// Self-checking bench for prime_checker_n: directed cases, clear/reset aborts and random operands
// compared against a plain-arithmetic trial-division model.
module tb_prime_checker_n;
   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;

   always #5 clk = ~clk;

   prime_checker_n_if #(.WIDTH(W)) bus();

   prime_checker_n #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear),
      .bus     (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int last_prime  = 0;
   int last_factor = 0;
   int last_trials = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference: straightforward trial division on integers.
   function automatic void model(input int n, output int prime, output int factor, output int trials);
      prime  = 0;
      factor = 0;
      trials = 0;
      if (n < 2) return;
      if (n % 2 == 0) begin
         prime  = (n == 2) ? 1 : 0;
         factor = (n == 2) ? 0 : 2;
         return;
      end
      for (int d = 3; d * d <= n; d += 2) begin
         trials++;
         if (n % d == 0) begin
            factor = d;
            return;
         end
      end
      prime = 1;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input int n);
      for (int i = 0; i < 50 && bus.in_ready_o !== 1'b1; i++) cycle();
      check("in_ready_before_accept", 32'(bus.in_ready_o), 32'd1);
      bus.data_i     = W'(n);
      bus.in_valid_i = 1'b1;
      cycle();
      bus.in_valid_i = 1'b0;
      bus.data_i     = W'($urandom);
   endtask

   task automatic run_op(input int n, input int bp);
      int ep, ef, et, lat;
      model(n, ep, ef, et);
      accept(n);
      bus.out_ready_i = (bp == 0);
      lat = 0;
      do begin
         cycle();
         lat++;
      end while (bus.out_valid_o !== 1'b1 && lat < 1000);
      check("latency", 32'(lat), 32'(1 + et * (W + 1)));
      check("prime", 32'(bus.prime_o), 32'(ep));
      check("factor", 32'(bus.factor_o), 32'(ef));
      check("trials", 32'(bus.trials_o), 32'(et));
      for (int i = 0; i < bp; i++) begin
         bus.in_valid_i = 1'($urandom_range(0, 1));
         bus.data_i     = W'($urandom);
         cycle();
         check("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
         check("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
         check("bp_factor", 32'(bus.factor_o), 32'(ef));
         check("bp_trials", 32'(bus.trials_o), 32'(et));
      end
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      cycle();
      bus.out_ready_i = 1'b0;
      check("post_out_valid", 32'(bus.out_valid_o), 32'd0);
      check("post_in_ready", 32'(bus.in_ready_o), 32'd1);
      check("post_prime_held", 32'(bus.prime_o), 32'(ep));
      check("post_factor_held", 32'(bus.factor_o), 32'(ef));
      last_prime  = ep;
      last_factor = ef;
      last_trials = et;
      $display("op n=%0d bp=%0d prime=%0d factor=%0d trials=%0d latency=%0d",
               n, bp, bus.prime_o, bus.factor_o, bus.trials_o, lat);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
      check({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
      check({tag, "_prime"}, 32'(bus.prime_o), 32'd0);
      check({tag, "_factor"}, 32'(bus.factor_o), 32'd0);
      check({tag, "_trials"}, 32'(bus.trials_o), 32'd0);
   endtask

   initial begin
      int seen;
      int directed_n[9];
      int directed_bp[9];
      directed_n  = '{0, 1, 2, 4, 7, 9, 251, 221, 25};
      directed_bp = '{0, 0, 0, 0, 0, 1, 1, 2, 5};

      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b0;
      bus.data_i      = '0;

      repeat (2) cycle();
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      foreach (directed_n[i]) run_op(directed_n[i], directed_bp[i]);

      // Abort n=221 three cycles into DIV.
      accept(221);
      repeat (3) cycle();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      check("clear_out_valid", 32'(bus.out_valid_o), 32'd0);
      check("clear_in_ready", 32'(bus.in_ready_o), 32'd1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (bus.out_valid_o === 1'b1) seen++;
      end
      check("clear_no_result", 32'(seen), 32'd0);
      check("clear_factor_kept", 32'(bus.factor_o), 32'(last_factor));
      check("clear_trials_kept", 32'(bus.trials_o), 32'(last_trials));
      $display("op clear during n=221 observed_valid_cycles=%0d", seen);
      run_op(13, 1);

      // Asynchronous reset in the middle of a division.
      accept(221);
      repeat (4) cycle();
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_reset");
      $display("op async reset during n=221");
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      run_op(221, 0);

      for (int i = 0; i < 40; i++) begin
         int n;
         n = (i % 3 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 127) * 2 + 1);
         run_op(n, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/prime_checker_n.md
# prime_checker_n

Parametrised, multi-cycle primality tester with valid/ready handshakes on both sides. It accepts one WIDTH-bit operand and returns a prime flag, the smallest nontrivial factor and the trial count. It uses trial division by 2, then odd divisors only, and stops once divisor² exceeds the operand. It sits between the operand source (user input / stimulus FSM) and the result consumer (display / scoreboard).

## Interface
- WIDTH, 8: operand width in bits (≥ 2)
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- clear_i  in  1  synchronous abort: return to IDLE, drop operation
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  block can accept operand (high only in IDLE)
- data_i  in  WIDTH  operand n (unsigned)
- out_valid_o  out  1  result valid, held until consumed
- out_ready_i  in  1  consumer accepts result
- prime_o  out  1  1 = n prime
- factor_o  out  WIDTH  smallest factor > 1 when not prime; 0 when prime or n < 2
- trials_o  out  WIDTH  number of remainder operations (DIV passes) performed

## Operation
- States, one-hot: IDLE, CHECK, DIV, EVAL, DONE.
- IDLE: in_ready_o = 1. On in_valid_i && in_ready_o: latch n, clear trials, set divisor d = 3, go to CHECK.
- CHECK, single cycle, trivial cases:
  - n < 2: not prime, factor 0 → DONE.
  - n = 2 or 3: prime → DONE.
  - n even: not prime, factor 2 → DONE.
  - 9 > n: prime → DONE.
  - Otherwise → DIV.
- DIV: pulse start to seq_mod with (n, d) and increment trials. Wait for done, then go to EVAL.
- EVAL, single cycle:
  - rem == 0: not prime, factor = d → DONE.
  - Otherwise: d += 2. If d² > n: prime → DONE. Else → DIV.
- DONE:
  - out_valid_o = 1; prime_o, factor_o, trials_o are stable.
  - On out_ready_i: → IDLE.
- Arithmetic: d is WIDTH+1 bits and the d² compare is 2·WIDTH+2 bits, so d never wraps.
- Result registers are loaded on entry to DONE. They hold their value after the handshake until the next result.
- in_valid_i is ignored outside IDLE. data_i is sampled only at acceptance.
- clear_i, any state: next state IDLE, out_valid_o = 0, seq_mod aborted; result registers keep their value. clear_i has priority over every handshake in the same cycle.
- Reset values: in_ready_o = 1, out_valid_o = 0, prime_o = 0, factor_o = 0, trials_o = 0, state IDLE.
- Reset mid-operation: immediate (asynchronous) return to these values.

## Timing
- Acceptance edge t; out_valid_o rises at edge t + 1 + k·(WIDTH+1), where k = trials_o.
- seq_mod:
  - Restoring division, one quotient bit per cycle.
  - done is a one-cycle pulse exactly WIDTH cycles after start; rem is valid with done.
- Each trial costs WIDTH cycles in DIV plus 1 in EVAL.
- DONE → IDLE on the out_ready_i edge; in_ready_o is high the following cycle.
  - No same-cycle result-consume + operand-accept (one bubble minimum).
- out_ready_i high before out_valid_o has no effect.

## Structure
- prime_pkg:
  - state_t (one-hot enum: IDLE, CHECK, DIV, EVAL, DONE)
  - default WIDTH constant
  - localparam for the first odd divisor (3)
- Sub-module seq_mod #(WIDTH):
  - ports clk, rst_n, abort_i, start_i, dividend_i, divisor_i, done_o, rem_o
  - abort_i is driven by clear_i

## Test plan
- WIDTH=8, n = 0, 1, 2, 4, 7 (back-to-back) → each out_valid_o 1 cycle after acceptance; prime_o/factor_o/trials_o respectively: 0/0/0, 0/0/0, 1/0/0, 0/2/0, 1/0/0.
- n = 9 → out_valid_o at t+10; prime_o = 0, factor_o = 3, trials_o = 1.
- n = 251 → out_valid_o at t+64; prime_o = 1, factor_o = 0, trials_o = 7. n = 221 → factor_o = 13, trials_o = 6, latency 55.
- Backpressure: n = 25, out_ready_i low 5 cycles after out_valid_o → outputs stable (0/5/2); in_valid_i pulses ignored; in_ready_o high 1 cycle after the handshake.
- clear_i asserted 3 cycles into DIV for n = 221 → IDLE next cycle, out_valid_o never asserted; a following n = 13 → prime_o = 1, trials_o = 1.
- rst_n pulsed mid-DIV → all outputs at reset values asynchronously; next operand processed correctly.
